// File: rtl/ex_mem_pkg.sv
// Shared types and helpers for the EX/MEM pipeline register.
package ex_mem_pkg;

  localparam int unsigned DataWDefault = 32;
  localparam int unsigned RegWDefault  = 5;

  // Overflow-exception controller states.
  typedef enum logic {
    StIdle,
    StPending
  } exc_state_e;

  // Signed overflow of a real instruction raises an exception; unsigned ops never trap.
  function automatic logic is_trap(input logic valid, input logic overflow, input logic unsig);
    return valid & overflow & ~unsig;
  endfunction

endpackage

// File: rtl/ex_mem_exc_ctrl.sv
// Overflow exception controller: FSM, EPC latch, saturating trap counter, flush pulse.
module ex_mem_exc_ctrl
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              trap,
  input  logic              exc_ack,
  input  logic [DATA_W-1:0] ex_pc,
  output logic              squash,
  output logic              exc_pending,
  output logic              exc_flush,
  output logic [DATA_W-1:0] exc_epc,
  output logic [CNT_W-1:0]  exc_count
);

  exc_state_e        state_q, state_d;
  logic [DATA_W-1:0] epc_q, epc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flush_q, flush_d;
  logic              idle_eff;

  // An ack at this edge returns to IDLE, so this edge's capture is treated as an IDLE capture.
  assign idle_eff = (state_q == StIdle) | exc_ack;

  // Next-state: flush freezes the controller; stall still honours the ack.
  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    squash  = 1'b0;
    if (!flush) begin
      if ((state_q == StPending) && exc_ack) begin
        state_d = StIdle;
      end
      if (!stall) begin
        if (!idle_eff) begin
          squash = 1'b1;
        end else if (trap) begin
          squash  = 1'b1;
          state_d = StPending;
          epc_d   = ex_pc;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          flush_d = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      epc_q   <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  assign exc_pending = (state_q == StPending);
  assign exc_flush   = flush_q;
  assign exc_epc     = epc_q;
  assign exc_count   = cnt_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with precise signed-overflow exceptions.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned REG_W  = RegWDefault,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic [DATA_W-1:0] ex_aluout,
  input  logic              ex_overflow,
  input  logic              ex_unsig,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_dest,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              exc_ack,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_pc,
  output logic [DATA_W-1:0] mem_aluout,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_dest,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              exc_pending,
  output logic              exc_flush,
  output logic [DATA_W-1:0] exc_epc,
  output logic [CNT_W-1:0]  exc_count
);

  logic              trap;
  logic              squash;
  logic              live;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] sd_q, sd_d;
  logic [REG_W-1:0]  dest_q, dest_d;
  logic              rw_q, rw_d;
  logic              mr_q, mr_d;
  logic              mw_q, mw_d;

  assign trap = is_trap(ex_valid, ex_overflow, ex_unsig);
  assign live = ex_valid & ~squash;

  ex_mem_exc_ctrl #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_exc_ctrl (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .trap        (trap),
    .exc_ack     (exc_ack),
    .ex_pc       (ex_pc),
    .squash      (squash),
    .exc_pending (exc_pending),
    .exc_flush   (exc_flush),
    .exc_epc     (exc_epc),
    .exc_count   (exc_count)
  );

  // Next-state: flush bubbles (data held), stall holds, otherwise capture with squash applied.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    alu_d   = alu_q;
    sd_d    = sd_q;
    dest_d  = dest_q;
    rw_d    = rw_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    if (flush) begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
    end else if (!stall) begin
      valid_d = live;
      pc_d    = ex_pc;
      alu_d   = ex_aluout;
      sd_d    = ex_store_data;
      dest_d  = ex_dest;
      rw_d    = ex_reg_write & live;
      mr_d    = ex_mem_read & live;
      mw_d    = ex_mem_write & live;
    end
  end

  // MEM-stage registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      alu_q   <= '0;
      sd_q    <= '0;
      dest_q  <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      sd_q    <= sd_d;
      dest_q  <= dest_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_pc         = pc_q;
  assign mem_aluout     = alu_q;
  assign mem_store_data = sd_q;
  assign mem_dest       = dest_q;
  assign mem_reg_write  = rw_q;
  assign mem_mem_read   = mr_q;
  assign mem_mem_write  = mw_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: vector table with scoreboard plus corner sequences.
module tb_ex_mem_stage;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu;
    logic        ovf;
    logic        unsig;
    logic [31:0] sd;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        ack;
  } stim_t;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        pend;
    logic        ef;
    logic [31:0] epc;
    logic [15:0] cnt;
  } want_t;

  typedef struct {
    stim_t s;
    want_t w;
  } vec_t;

  logic clock = 1'b0;
  logic reset, stall, flush, ex_valid, ex_overflow, ex_unsig;
  logic ex_reg_write, ex_mem_read, ex_mem_write, exc_ack;
  logic [31:0] ex_pc, ex_aluout, ex_store_data;
  logic [4:0]  ex_dest;

  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, exc_pending, exc_flush;
  logic [31:0] mem_pc, mem_aluout, mem_store_data, exc_epc;
  logic [4:0]  mem_dest;
  logic [15:0] exc_count;

  logic        s_valid, s_reg_write, s_mem_read, s_mem_write, s_pending, s_flush;
  logic [31:0] s_pc, s_aluout, s_store_data, s_epc;
  logic [4:0]  s_dest;
  logic [3:0]  s_count;

  int n_checks = 0;
  int n_errors = 0;
  want_t exp_q[$];
  vec_t  vecs[$];

  always #5 clock = ~clock;

  ex_mem_stage u_dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_aluout      (ex_aluout),
    .ex_overflow    (ex_overflow),
    .ex_unsig       (ex_unsig),
    .ex_store_data  (ex_store_data),
    .ex_dest        (ex_dest),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .exc_ack        (exc_ack),
    .mem_valid      (mem_valid),
    .mem_pc         (mem_pc),
    .mem_aluout     (mem_aluout),
    .mem_store_data (mem_store_data),
    .mem_dest       (mem_dest),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_read   (mem_mem_read),
    .mem_mem_write  (mem_mem_write),
    .exc_pending    (exc_pending),
    .exc_flush      (exc_flush),
    .exc_epc        (exc_epc),
    .exc_count      (exc_count)
  );

  // Narrow-counter copy so saturation is reachable in a few cycles.
  ex_mem_stage #(
    .CNT_W (4)
  ) u_dut_sat (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_aluout      (ex_aluout),
    .ex_overflow    (ex_overflow),
    .ex_unsig       (ex_unsig),
    .ex_store_data  (ex_store_data),
    .ex_dest        (ex_dest),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .exc_ack        (exc_ack),
    .mem_valid      (s_valid),
    .mem_pc         (s_pc),
    .mem_aluout     (s_aluout),
    .mem_store_data (s_store_data),
    .mem_dest       (s_dest),
    .mem_reg_write  (s_reg_write),
    .mem_mem_read   (s_mem_read),
    .mem_mem_write  (s_mem_write),
    .exc_pending    (s_pending),
    .exc_flush      (s_flush),
    .exc_epc        (s_epc),
    .exc_count      (s_count)
  );

  function automatic stim_t mk_s(logic st, logic fl, logic v, logic [31:0] pc, logic [31:0] alu,
                                 logic ovf, logic un, logic [31:0] sd, logic [4:0] d,
                                 logic rw, logic mr, logic mw, logic ack);
    stim_t s;
    s = '{st, fl, v, pc, alu, ovf, un, sd, d, rw, mr, mw, ack};
    return s;
  endfunction

  function automatic want_t mk_w(logic v, logic [31:0] pc, logic [31:0] alu, logic [31:0] sd,
                                 logic [4:0] d, logic rw, logic mr, logic mw, logic pend,
                                 logic ef, logic [31:0] epc, logic [15:0] cnt);
    want_t w;
    w = '{v, pc, alu, sd, d, rw, mr, mw, pend, ef, epc, cnt};
    return w;
  endfunction

  function automatic want_t observed();
    want_t w;
    w = {mem_valid, mem_pc, mem_aluout, mem_store_data, mem_dest, mem_reg_write, mem_mem_read,
         mem_mem_write, exc_pending, exc_flush, exc_epc, exc_count};
    return w;
  endfunction

  task automatic drive(input stim_t s);
    stall         = s.stall;
    flush         = s.flush;
    ex_valid      = s.valid;
    ex_pc         = s.pc;
    ex_aluout     = s.alu;
    ex_overflow   = s.ovf;
    ex_unsig      = s.unsig;
    ex_store_data = s.sd;
    ex_dest       = s.dest;
    ex_reg_write  = s.rw;
    ex_mem_read   = s.mr;
    ex_mem_write  = s.mw;
    exc_ack       = s.ack;
  endtask

  task automatic check_state(input string name, input want_t got, input want_t want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input stim_t s);
    @(negedge clock);
    drive(s);
    @(posedge clock);
    #1;
  endtask

  initial begin
    stim_t idle_s;
    want_t zero_w;
    want_t w;
    idle_s = mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    zero_w = '0;

    // Sequential scenario; each row is one clock edge and its expected post-edge state.
    vecs.push_back('{mk_s(0, 0, 1, 32'h0040_0000, 32'h8000_0000, 1, 1, 32'h11, 3, 1, 0, 0, 0),
                     mk_w(1, 32'h0040_0000, 32'h8000_0000, 32'h11, 3, 1, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{mk_s(0, 0, 1, 32'h0040_0004, 32'h1000, 0, 0, 32'h22, 4, 1, 1, 0, 0),
                     mk_w(1, 32'h0040_0004, 32'h1000, 32'h22, 4, 1, 1, 0, 0, 0, 0, 0)});
    vecs.push_back('{mk_s(0, 0, 0, 32'h0040_0008, 32'h2000, 0, 0, 32'h33, 0, 0, 0, 1, 0),
                     mk_w(0, 32'h0040_0008, 32'h2000, 32'h33, 0, 0, 0, 0, 0, 0, 0, 0)});
    // flush and trap together: bubble, data held, no exception
    vecs.push_back('{mk_s(0, 1, 1, 32'h0040_000C, 32'h8000_0000, 1, 0, 32'h44, 9, 1, 0, 0, 0),
                     mk_w(0, 32'h0040_0008, 32'h2000, 32'h33, 0, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{mk_s(0, 0, 1, 32'h0040_0100, 32'hC, 0, 0, 32'hCC, 10, 1, 1, 0, 0),
                     mk_w(1, 32'h0040_0100, 32'hC, 32'hCC, 10, 1, 1, 0, 0, 0, 0, 0)});
    // two stall cycles, the second with a trapping instruction
    vecs.push_back('{mk_s(1, 0, 1, 32'h0040_0104, 32'hD, 0, 0, 32'hDD, 11, 0, 0, 1, 0),
                     mk_w(1, 32'h0040_0100, 32'hC, 32'hCC, 10, 1, 1, 0, 0, 0, 0, 0)});
    vecs.push_back('{mk_s(1, 0, 1, 32'h0040_0108, 32'h8000_0000, 1, 0, 32'hEE, 12, 1, 0, 0, 0),
                     mk_w(1, 32'h0040_0100, 32'hC, 32'hCC, 10, 1, 1, 0, 0, 0, 0, 0)});
    // signed overflow trap
    vecs.push_back('{mk_s(0, 0, 1, 32'h0040_0010, 32'h8000_0000, 1, 0, 32'h44, 5, 1, 0, 0, 0),
                     mk_w(0, 32'h0040_0010, 32'h8000_0000, 32'h44, 5, 0, 0, 0, 1, 1,
                          32'h0040_0010, 1)});
    // pending: three valid instructions squashed, one overflowing
    vecs.push_back('{mk_s(0, 0, 1, 32'h0040_0014, 32'h5, 0, 0, 32'h55, 6, 1, 0, 0, 0),
                     mk_w(0, 32'h0040_0014, 32'h5, 32'h55, 6, 0, 0, 0, 1, 0, 32'h0040_0010, 1)});
    vecs.push_back('{mk_s(0, 0, 1, 32'h0040_0018, 32'h7FFF_FFFF, 1, 0, 32'h66, 7, 1, 0, 0, 0),
                     mk_w(0, 32'h0040_0018, 32'h7FFF_FFFF, 32'h66, 7, 0, 0, 0, 1, 0,
                          32'h0040_0010, 1)});
    vecs.push_back('{mk_s(0, 0, 1, 32'h0040_001C, 32'h9, 0, 0, 32'h77, 0, 0, 0, 1, 0),
                     mk_w(0, 32'h0040_001C, 32'h9, 32'h77, 0, 0, 0, 0, 1, 0, 32'h0040_0010, 1)});
    // stall with ack: ack taken, data held
    vecs.push_back('{mk_s(1, 0, 1, 32'h0040_0020, 32'hB, 0, 0, 32'hBB, 2, 1, 0, 0, 1),
                     mk_w(0, 32'h0040_001C, 32'h9, 32'h77, 0, 0, 0, 0, 0, 0, 32'h0040_0010, 1)});
    vecs.push_back('{mk_s(0, 0, 1, 32'h0040_0020, 32'hA, 0, 0, 32'h88, 8, 1, 0, 0, 0),
                     mk_w(1, 32'h0040_0020, 32'hA, 32'h88, 8, 1, 0, 0, 0, 0, 32'h0040_0010, 1)});
    // second trap, then ack with a live instruction captured on the same edge
    vecs.push_back('{mk_s(0, 0, 1, 32'h0040_0024, 32'h8000_0000, 1, 0, 32'h99, 9, 1, 0, 0, 0),
                     mk_w(0, 32'h0040_0024, 32'h8000_0000, 32'h99, 9, 0, 0, 0, 1, 1,
                          32'h0040_0024, 2)});
    vecs.push_back('{mk_s(0, 0, 1, 32'h0040_0028, 32'hF, 0, 0, 32'hFF, 1, 1, 0, 1, 1),
                     mk_w(1, 32'h0040_0028, 32'hF, 32'hFF, 1, 1, 0, 1, 0, 0, 32'h0040_0024, 2)});
    // ack while idle is ignored
    vecs.push_back('{mk_s(0, 0, 1, 32'h0040_002C, 32'h10, 0, 0, 32'h0, 2, 0, 1, 0, 1),
                     mk_w(1, 32'h0040_002C, 32'h10, 32'h0, 2, 0, 1, 0, 0, 0, 32'h0040_0024, 2)});

    reset = 1'b1;
    drive(idle_s);
    repeat (2) @(posedge clock);
    #1;
    check_state("reset_state", observed(), zero_w);
    check_val("reset_sat_count", 32'(s_count), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].s);
      exp_q.push_back(vecs[i].w);
      @(posedge clock);
      #1;
      w = exp_q.pop_front();
      check_state($sformatf("vec%0d", i), observed(), w);
    end

    // Reset while an exception is pending.
    step(mk_s(0, 0, 1, 32'h0040_0030, 32'h8000_0000, 1, 0, 32'h1, 1, 1, 0, 0, 0));
    check_val("pend_before_reset", 32'(exc_pending), 32'h1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_state("reset_while_pending", observed(), zero_w);
    @(negedge clock);
    reset = 1'b0;

    // Saturation: 17 trap/ack pairs; 4-bit counter pins at 0xF, 16-bit counter reaches 17.
    for (int k = 1; k <= 17; k++) begin
      step(mk_s(0, 0, 1, 32'h0040_0100 + 32'(4 * k), 32'h8000_0000, 1, 0, 32'h0, 1, 1, 0, 0, 0));
      check_val($sformatf("sat_count_%0d", k), 32'(s_count), (k > 15) ? 32'd15 : 32'(k));
      step(mk_s(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 1));
    end
    check_val("sat_pending_clear", 32'(s_pending), 32'h0);
    check_val("sat_epc", s_epc, 32'h0040_0144);
    check_val("wide_count", 32'(exc_count), 32'd17);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM pipeline register for the 32-bit MIPS datapath. Sits directly downstream of the ALU: it captures the ALU result, overflow flag and forwarded EX-stage control into the MEM stage. It also converts a signed arithmetic overflow into a precise exception: the faulting instruction is squashed, its PC is latched as EPC, and the pipeline is held in a pending state until the exception is acknowledged.

## Interface
- DATA_W, 32, datapath and PC width
- REG_W, 5, destination register index width
- CNT_W, 16, overflow event counter width

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  hold all MEM-stage state
- flush  in  1  insert a bubble into MEM
- ex_valid  in  1  EX holds a real instruction
- ex_pc  in  DATA_W  PC of the EX instruction
- ex_aluout  in  DATA_W  ALU result
- ex_overflow  in  1  ALU overflow flag
- ex_unsig  in  1  unsigned op; overflow must not trap
- ex_store_data  in  DATA_W  rt value for stores
- ex_dest  in  REG_W  destination register
- ex_reg_write, ex_mem_read, ex_mem_write  in  1 each  control bits
- exc_ack  in  1  exception handler has consumed EPC
- mem_valid  out  1; mem_pc, mem_aluout, mem_store_data  out  DATA_W; mem_dest  out  REG_W
- mem_reg_write, mem_mem_read, mem_mem_write  out  1 each
- exc_pending  out  1  overflow exception outstanding
- exc_flush  out  1  one-cycle request to flush IF/ID/EX
- exc_epc  out  DATA_W  PC of the faulting instruction
- exc_count  out  CNT_W  saturating count of trapped overflows

## Operation
- trap = ex_valid & ex_overflow & ~ex_unsig.
- Priority at each edge: reset > flush > stall > normal capture.
- reset: every output is 0 and the FSM enters IDLE.
- flush: mem_valid and the three enables go to 0; data fields hold; no trap is taken even if trap=1; FSM state, exc_epc and exc_count are unchanged.
- stall (no flush): every mem_* output holds; trap is not evaluated; exc_flush is 0; exc_ack is still honoured.
- Normal capture, FSM IDLE, trap=0: every ex_* field is copied to mem_*. mem_valid = ex_valid. The enables are ANDed with ex_valid.
- Normal capture, FSM IDLE, trap=1: the MEM slot receives a bubble (mem_valid and enables 0, data fields still copied). exc_epc <= ex_pc. exc_count increments and saturates at all-ones. FSM goes to PENDING. exc_flush = 1 for the next cycle only.
- FSM PENDING: every capture is forced to a bubble. Further traps are ignored: no EPC update, no count. When exc_ack=1, FSM goes to IDLE at that edge, and normal capture resumes in the same edge.
- exc_ack while IDLE: ignored.
- exc_pending = (FSM == PENDING). exc_epc holds until the next trap or reset.

## Timing
- Latency is 1 cycle from ex_* to mem_*. All outputs are registered. There is no combinational path from input to output.
- A trap captured at edge N gives exc_pending=1, exc_flush=1 and a valid exc_epc in cycle N+1. exc_flush drops in cycle N+2.
- exc_ack sampled at edge M gives exc_pending=0 in cycle M+1. The EX instruction presented at edge M is captured normally.
- Simultaneous flush and trap: flush wins and no exception is taken.
- Simultaneous stall and exc_ack: the ack is taken and the data holds.
- Reset while PENDING: returns to IDLE, clears exc_epc and exc_count, and drops the pending exception.

## Structure
- Shared package:
  - FSM state enum (IDLE, PENDING)
  - DATA_W/REG_W defaults
  - the trap predicate as a function, reused by the ALU control/decoder
- One natural sub-module: ex_mem_exc_ctrl. It holds the FSM, exc_epc, exc_count and the exc_flush pulse, and outputs a squash signal to the register datapath.

## Test plan
- Signed add overflow: ex_pc=0x0040_0010, ex_aluout=0x8000_0000, overflow=1, unsig=0, reg_write=1 -> next cycle mem_valid=0, mem_reg_write=0, exc_epc=0x0040_0010, exc_flush=1 for exactly one cycle, exc_count=1.
- Same stimulus with unsig=1 -> mem_valid=1, mem_aluout=0x8000_0000, mem_reg_write=1, exc_pending stays 0.
- While PENDING, present 3 valid instructions, one of them overflowing -> all become bubbles, exc_epc unchanged, exc_count stays 1. Assert exc_ack -> the next instruction passes through.
- Present flush and trap in the same cycle -> bubble, exc_pending=0, exc_count=0. Then hold stall for 2 cycles -> mem_* hold.
- Assert reset while PENDING -> all outputs 0 the next cycle. Preload exc_count at 0xFFFF, then trap -> count stays 0xFFFF.
